// File: rtl/plc_scan_ctrl.sv
// Scan-cycle sequencer for the PLC uP core: latch inputs, start the CPU,
// bound its execution with a watchdog, commit outputs on a fixed period.
module plc_scan_ctrl #(
    parameter int IN_W        = 8,
    parameter int OUT_W       = 8,
    parameter int SCAN_PERIOD = 1000,
    parameter int WDT_LIMIT   = 800,
    parameter int CNT_W       = 16
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             run_in,
    input  logic [IN_W-1:0]  in_raw_in,
    output logic [IN_W-1:0]  in_img_out,
    input  logic [OUT_W-1:0] cpu_out_img_in,
    output logic [OUT_W-1:0] out_img_out,
    output logic             cpu_start_out,
    input  logic             cpu_done_in,
    output logic             cpu_rst_out,
    output logic             fault_out,
    output logic             overrun_out,
    input  logic             fault_clr_in,
    output logic [CNT_W-1:0] scan_cnt_out,
    output logic             busy_out
);

    localparam int PT_W = $clog2(SCAN_PERIOD + 1);
    localparam int WD_W = $clog2(WDT_LIMIT + 1);
    localparam logic [PT_W-1:0] PT_LAST = PT_W'(SCAN_PERIOD - 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(WDT_LIMIT - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LATCH  = 3'd1,
        ST_START  = 3'd2,
        ST_EXEC   = 3'd3,
        ST_OUTPUT = 3'd4,
        ST_WAIT   = 3'd5,
        ST_FAULT  = 3'd6
    } state_t;

    state_t             state_r;
    state_t             state_s;
    logic [PT_W-1:0]    ptmr_r;
    logic [WD_W-1:0]    wdt_r;
    logic [IN_W-1:0]    in_img_r;
    logic [OUT_W-1:0]   out_img_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               fault_r;
    logic               overrun_r;
    logic               start_r;
    logic               cpu_rst_r;
    logic               busy_r;
    logic               period_end_s;
    logic               fault_entry_s;
    logic               idle_like_s;

    // The timer saturates, so "reached" and "equal to" the last tick coincide.
    assign period_end_s  = (ptmr_r >= PT_LAST);
    assign fault_entry_s = (state_r == ST_EXEC) && (state_s == ST_FAULT);
    assign idle_like_s   = (state_s == ST_IDLE) || (state_s == ST_FAULT);

    // Next-state logic of the scan sequencer.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (run_in) state_s = ST_LATCH;
                else        state_s = ST_IDLE;
            end
            ST_LATCH:  state_s = ST_START;
            ST_START:  state_s = ST_EXEC;
            ST_EXEC: begin
                // Done has priority over the watchdog limit in the same cycle.
                if (cpu_done_in)             state_s = ST_OUTPUT;
                else if (wdt_r == WD_LAST)   state_s = ST_FAULT;
                else                         state_s = ST_EXEC;
            end
            ST_OUTPUT: begin
                if (period_end_s) state_s = run_in ? ST_LATCH : ST_IDLE;
                else              state_s = ST_WAIT;
            end
            ST_WAIT: begin
                if (period_end_s) state_s = run_in ? ST_LATCH : ST_IDLE;
                else              state_s = ST_WAIT;
            end
            ST_FAULT: begin
                if (fault_clr_in && !run_in) state_s = ST_IDLE;
                else                         state_s = ST_FAULT;
            end
            default:   state_s = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_r <= ST_IDLE;
        else         state_r <= state_s;
    end

    // Period timer: zero during LATCH, then counts up and saturates.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                    ptmr_r <= '0;
        else if (state_s == ST_LATCH)   ptmr_r <= '0;
        else if (ptmr_r < PT_LAST)      ptmr_r <= ptmr_r + PT_W'(1);
        else                            ptmr_r <= ptmr_r;
    end

    // Watchdog: zero on entry to EXEC, counts EXEC cycles.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                  wdt_r <= '0;
        else if (state_r == ST_EXEC)  wdt_r <= wdt_r + WD_W'(1);
        else                          wdt_r <= '0;
    end

    // Input image is captured only at the end of LATCH.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                   in_img_r <= '0;
        else if (state_r == ST_LATCH)  in_img_r <= in_raw_in;
        else                           in_img_r <= in_img_r;
    end

    // Output image: commit after OUTPUT, force safe zero on fault entry.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                    out_img_r <= '0;
        else if (state_r == ST_OUTPUT)  out_img_r <= cpu_out_img_in;
        else if (fault_entry_s)         out_img_r <= '0;
        else                            out_img_r <= out_img_r;
    end

    // Completed-scan counter, wraps naturally.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                    cnt_r <= '0;
        else if (state_r == ST_OUTPUT)  cnt_r <= cnt_r + CNT_W'(1);
        else                            cnt_r <= cnt_r;
    end

    // Sticky overrun: set on a late OUTPUT; inside FAULT it clears only on exit.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in)                                  overrun_r <= 1'b0;
        else if ((state_r == ST_OUTPUT) && period_end_s) overrun_r <= 1'b1;
        else if (state_r == ST_FAULT)                 overrun_r <= (state_s == ST_IDLE) ? 1'b0 : overrun_r;
        else if (fault_clr_in)                        overrun_r <= 1'b0;
        else                                          overrun_r <= overrun_r;
    end

    // State-decoded control outputs, registered from the next state.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            start_r   <= 1'b0;
            cpu_rst_r <= 1'b1;
            busy_r    <= 1'b0;
            fault_r   <= 1'b0;
        end else begin
            start_r   <= (state_s == ST_START);
            cpu_rst_r <= idle_like_s;
            busy_r    <= !idle_like_s;
            fault_r   <= (state_s == ST_FAULT);
        end
    end

    assign in_img_out    = in_img_r;
    assign out_img_out   = out_img_r;
    assign cpu_start_out = start_r;
    assign cpu_rst_out   = cpu_rst_r;
    assign fault_out     = fault_r;
    assign overrun_out   = overrun_r;
    assign scan_cnt_out  = cnt_r;
    assign busy_out      = busy_r;

endmodule

// File: tb/tb_plc_scan_ctrl.sv
// Randomized scoreboard bench for plc_scan_ctrl: expected scan starts and
// fault entries are queued by the stimulus and checked by a separate monitor.
module tb_plc_scan_ctrl;

    localparam int P  = 20;
    localparam int WL = 10;
    localparam int CW = 4;
    localparam int P2 = 12;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, run, done, clr;
    logic [7:0]    raw, cimg;
    logic [7:0]    in_img, out_img;
    logic          start, cpu_rst, fault, overrun, busy;
    logic [CW-1:0] cnt;

    logic          rst2, run2, done2, clr2;
    logic [7:0]    raw2, cimg2;
    logic [7:0]    in_img2, out_img2;
    logic          start2, cpu_rst2, fault2, overrun2, busy2;
    logic [CW-1:0] cnt2;

    plc_scan_ctrl #(.IN_W(8), .OUT_W(8), .SCAN_PERIOD(P), .WDT_LIMIT(WL), .CNT_W(CW)) dut (
        .clk_in(clk), .rst_in(rst_n), .run_in(run), .in_raw_in(raw), .in_img_out(in_img),
        .cpu_out_img_in(cimg), .out_img_out(out_img), .cpu_start_out(start),
        .cpu_done_in(done), .cpu_rst_out(cpu_rst), .fault_out(fault), .overrun_out(overrun),
        .fault_clr_in(clr), .scan_cnt_out(cnt), .busy_out(busy)
    );

    plc_scan_ctrl #(.IN_W(8), .OUT_W(8), .SCAN_PERIOD(P2), .WDT_LIMIT(WL), .CNT_W(CW)) dut2 (
        .clk_in(clk), .rst_in(rst2), .run_in(run2), .in_raw_in(raw2), .in_img_out(in_img2),
        .cpu_out_img_in(cimg2), .out_img_out(out_img2), .cpu_start_out(start2),
        .cpu_done_in(done2), .cpu_rst_out(cpu_rst2), .fault_out(fault2), .overrun_out(overrun2),
        .fault_clr_in(clr2), .scan_cnt_out(cnt2), .busy_out(busy2)
    );

    typedef struct {
        int            cyc;
        logic [7:0]    img_in;
        logic [CW-1:0] cnt;
        logic [7:0]    img_out;
    } start_exp_t;

    start_exp_t start_q[$];
    int         fault_q[$];
    int         checks   = 0;
    int         failures = 0;
    int         cyc      = 0;
    logic       start_prev = 1'b0;
    logic       fault_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compares every start pulse and fault entry against the queues.
    always @(negedge clk) begin
        start_exp_t e;
        int fc;
        if (start) begin
            chk("start_width", {31'd0, start_prev}, 32'd0);
            if (start_q.size() == 0) begin
                chk("start_unexpected", 32'd1, 32'd0);
            end else begin
                e = start_q.pop_front();
                chk("start_cycle", cyc, e.cyc);
                chk("start_in_img", {24'd0, in_img}, {24'd0, e.img_in});
                chk("start_scan_cnt", {28'd0, cnt}, {28'd0, e.cnt});
                chk("start_out_img", {24'd0, out_img}, {24'd0, e.img_out});
                chk("start_busy", {31'd0, busy}, 32'd1);
                chk("start_cpu_rst", {31'd0, cpu_rst}, 32'd0);
            end
        end
        if (fault && !fault_prev) begin
            if (fault_q.size() == 0) begin
                chk("fault_unexpected", 32'd1, 32'd0);
            end else begin
                fc = fault_q.pop_front();
                chk("fault_cycle", cyc, fc);
                chk("fault_out_img_safe", {24'd0, out_img}, 32'd0);
                chk("fault_cpu_rst", {31'd0, cpu_rst}, 32'd1);
                chk("fault_busy", {31'd0, busy}, 32'd0);
            end
        end
        start_prev <= start;
        fault_prev <= fault;
    end

    initial begin
        int            latch, next_latch, d, c0;
        bit            drop;
        logic [7:0]    data;
        logic [7:0]    exp_out;
        logic [CW-1:0] exp_cnt;

        rst_n = 1'b0; run = 1'b0; done = 1'b0; clr = 1'b0; raw = 8'h00; cimg = 8'h00;
        rst2 = 1'b0; run2 = 1'b0; done2 = 1'b0; clr2 = 1'b0; raw2 = 8'h00; cimg2 = 8'h00;
        repeat (3) tick();
        chk("rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("rst_out_img", {24'd0, out_img}, 32'd0);
        chk("rst_in_img", {24'd0, in_img}, 32'd0);
        chk("rst_scan_cnt", {28'd0, cnt}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_fault", {31'd0, fault}, 32'd0);
        chk("rst_start", {31'd0, start}, 32'd0);
        rst_n = 1'b1;
        tick();

        exp_cnt = '0;
        exp_out = 8'h00;
        raw = 8'hA5;
        run = 1'b1;
        next_latch = cyc + 1;

        for (int i = 0; i < 40; i++) begin
            latch = next_latch;
            d = (i == 0) ? 3 : (i == 5) ? WL : int'($urandom_range(1, WL));
            if (i == 18 || (i > 18 && $urandom_range(0, 9) == 0)) d = 0;
            drop = (i == 7) || (d != 0 && i > 0 && $urandom_range(0, 7) == 0);
            data = (i == 0) ? 8'h3C : 8'($urandom);
            start_q.push_back('{latch + 1, raw, exp_cnt, exp_out});
            if (d == 0) fault_q.push_back(latch + 2 + WL);

            while (cyc < latch + 1) tick();
            cimg = data;
            raw  = 8'($urandom);
            done = 1'($urandom_range(0, 1));
            tick();
            done = 1'b0;
            if (drop) run = 1'b0;
            if (d != 0) begin
                repeat (d - 1) tick();
                done = 1'b1;
                tick();
                done = 1'b0;
                exp_out = data;
                exp_cnt = exp_cnt + 4'd1;
                tick();
                chk("out_img_commit", {24'd0, out_img}, {24'd0, exp_out});
                chk("scan_cnt", {28'd0, cnt}, {28'd0, exp_cnt});
                chk("overrun_quiet", {31'd0, overrun}, 32'd0);
                if ($urandom_range(0, 1) == 1) begin
                    done = 1'b1;
                    tick();
                    done = 1'b0;
                end
                if (drop) begin
                    while (cyc < latch + P) tick();
                    chk("drop_idle_cpu_rst", {31'd0, cpu_rst}, 32'd1);
                    chk("drop_idle_busy", {31'd0, busy}, 32'd0);
                    chk("drop_out_img", {24'd0, out_img}, {24'd0, exp_out});
                    run = 1'b1;
                    next_latch = cyc + 1;
                end else begin
                    next_latch = latch + P;
                end
            end else begin
                while (cyc < latch + WL + 4) tick();
                clr = 1'b1;
                tick();
                chk("fault_hold_run", {31'd0, fault}, 32'd1);
                run = 1'b0;
                tick();
                clr = 1'b0;
                chk("fault_exit", {31'd0, fault}, 32'd0);
                chk("fault_exit_cpu_rst", {31'd0, cpu_rst}, 32'd1);
                chk("fault_exit_busy", {31'd0, busy}, 32'd0);
                exp_out = 8'h00;
                run = 1'b1;
                next_latch = cyc + 1;
            end
        end

        // Final scan, then asynchronous reset during WAIT.
        latch = next_latch;
        start_q.push_back('{latch + 1, raw, exp_cnt, exp_out});
        while (cyc < latch + 1) tick();
        cimg = 8'h3C;
        tick();
        done = 1'b1;
        tick();
        done = 1'b0;
        tick();
        chk("final_out_img", {24'd0, out_img}, 32'h3C);
        tick();
        rst_n = 1'b0;
        run = 1'b0;
        #1;
        chk("async_rst_out_img", {24'd0, out_img}, 32'd0);
        chk("async_rst_cnt", {28'd0, cnt}, 32'd0);
        chk("async_rst_cpu_rst", {31'd0, cpu_rst}, 32'd1);
        chk("async_rst_busy", {31'd0, busy}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("post_rst_idle", {31'd0, busy}, 32'd0);

        // Overrun instance: period 12, done on the watchdog limit cycle.
        rst2 = 1'b1;
        tick();
        run2 = 1'b1;
        c0 = cyc + 1;
        while (cyc < c0 + 1) tick();
        chk("ovr_start0", {31'd0, start2}, 32'd1);
        cimg2 = 8'h5A;
        tick();
        repeat (WL - 1) tick();
        done2 = 1'b1;
        tick();
        done2 = 1'b0;
        chk("ovr_not_fault", {31'd0, fault2}, 32'd0);
        chk("ovr_pre_flag", {31'd0, overrun2}, 32'd0);
        tick();
        chk("ovr_flag", {31'd0, overrun2}, 32'd1);
        chk("ovr_out_img", {24'd0, out_img2}, 32'h5A);
        chk("ovr_latch_busy", {31'd0, busy2}, 32'd1);
        chk("ovr_latch_nostart", {31'd0, start2}, 32'd0);
        tick();
        chk("ovr_restart", {31'd0, start2}, 32'd1);
        clr2 = 1'b1;
        tick();
        clr2 = 1'b0;
        chk("ovr_clr", {31'd0, overrun2}, 32'd0);
        chk("ovr_clr_fault", {31'd0, fault2}, 32'd0);
        run2 = 1'b0;

        repeat (5) tick();
        chk("start_q_drained", start_q.size(), 32'd0);
        chk("fault_q_drained", fault_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/plc_scan_ctrl.md
Name: plc_scan_ctrl

Overview:
- Scan-cycle sequencer for the uP core in the PLC.
- Runs the classic PLC loop with a fixed period: latch the input image, start the CPU, wait for it to finish, then commit the output image.
- A watchdog bounds each execution; an overrun or hang forces outputs to a safe state.
- Sits between the top-level I/O pins and the `up` core's start/done/image interface.

Parameters:
- IN_W, 8: width of the raw input bus and the input image.
- OUT_W, 8: width of the CPU output image and the output register.
- SCAN_PERIOD, 1000: clock cycles from one scan start (LATCH) to the next. Must be ≥ WDT_LIMIT+3.
- WDT_LIMIT, 800: maximum number of EXEC cycles allowed before a fault.
- CNT_W, 16: width of the scan counter.

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_in  input  1  asynchronous, active-low reset.
- run_in  input  1  level; 1 = perform scans.
- in_raw_in  input  IN_W  raw digital inputs.
- in_img_out  output  IN_W  latched input image, presented to the CPU.
- cpu_out_img_in  input  OUT_W  output image written by the CPU.
- out_img_out  output  OUT_W  committed physical outputs.
- cpu_start_out  output  1  one-cycle start pulse to the CPU.
- cpu_done_in  input  1  CPU finished the scan program; sampled only in EXEC.
- cpu_rst_out  output  1  holds the CPU in reset; active high.
- fault_out  output  1  sticky watchdog fault.
- overrun_out  output  1  sticky flag: a scan exceeded SCAN_PERIOD.
- fault_clr_in  input  1  clears fault_out and overrun_out.
- scan_cnt_out  output  CNT_W  count of completed scans; wraps modulo 2^CNT_W.
- busy_out  output  1  1 in every state except IDLE and FAULT.

Behaviour:
- Reset (rst_in=0, asynchronous): state=IDLE; all outputs 0 except cpu_rst_out=1; period timer, watchdog and scan_cnt_out all 0.
- States: IDLE, LATCH, START, EXEC, OUTPUT, WAIT, FAULT.
- Period timer: cleared to 0 in the LATCH cycle, then increments every cycle and saturates at SCAN_PERIOD-1.
- IDLE:
  - cpu_rst_out=1.
  - run_in=1 → LATCH next cycle.
- LATCH (1 cycle, scan cycle t=0):
  - in_img_out <= in_raw_in.
  - cpu_rst_out=0.
  - → START.
- START (1 cycle, t=1):
  - cpu_start_out=1 in this cycle only.
  - Watchdog cleared to 0.
  - → EXEC.
- EXEC:
  - Watchdog increments each cycle.
  - cpu_done_in=1 → OUTPUT.
  - Otherwise, if watchdog==WDT_LIMIT-1 → FAULT. EXEC therefore lasts at most WDT_LIMIT cycles.
  - If done and the limit occur in the same cycle, done wins.
- OUTPUT (1 cycle):
  - out_img_out <= cpu_out_img_in.
  - scan_cnt_out increments; wraps from 2^CNT_W-1 to 0.
  - If the period timer ≥ SCAN_PERIOD-1 this cycle, set overrun_out and skip WAIT: go to LATCH if run_in else IDLE.
  - Otherwise → WAIT.
- WAIT:
  - When period timer==SCAN_PERIOD-1 → LATCH if run_in, else IDLE.
  - Next LATCH falls exactly at t=SCAN_PERIOD.
- run_in deassert mid-scan: the current scan completes through OUTPUT/WAIT, then the block enters IDLE. The CPU is never cut off mid-execution.
- FAULT:
  - fault_out=1, cpu_rst_out=1, busy_out=0.
  - out_img_out forced to 0 (safe state) on entry.
  - Exit to IDLE only when fault_clr_in=1 and run_in=0 in the same cycle; this clears fault_out and overrun_out.
- fault_clr_in in a non-FAULT state clears overrun_out only.
- cpu_done_in outside EXEC is ignored, including a done asserted during START.
- in_img_out changes only in LATCH. out_img_out changes only in OUTPUT, in FAULT entry, or on reset.
- Reset mid-scan: immediate return to reset values. out_img_out goes to 0 with no glitch to other values.

Test Plan:
(All cases use SCAN_PERIOD=20, WDT_LIMIT=10, CNT_W=4.)
1. Reset, run_in=1, in_raw_in=0xA5, CPU returns done 3 cycles after start with cpu_out_img_in=0x3C:
   - cpu_start_out high exactly 1 cycle, at t=1.
   - in_img_out=0xA5 from t=1.
   - out_img_out=0x3C after OUTPUT.
   - scan_cnt_out=1.
   - Next cpu_start_out at t=21.
2. CPU never asserts done:
   - FAULT entered after 10 EXEC cycles; fault_out=1, out_img_out=0, cpu_rst_out=1.
   - fault_clr_in=1 with run_in=1 → stays in FAULT.
   - fault_clr_in=1 with run_in=0 → IDLE, fault_out=0.
3. cpu_done_in asserted on the 10th EXEC cycle (limit cycle) → OUTPUT taken, no fault.
4. Period overrun: override SCAN_PERIOD=12, CPU done on the 10th EXEC cycle → overrun_out=1 and LATCH immediately follows OUTPUT.
5. run_in dropped during EXEC → scan completes, out_img_out updated, then IDLE with cpu_rst_out=1. 16 consecutive scans wrap scan_cnt_out 15→0.
6. rst_in pulsed low during WAIT with out_img_out=0x3C → out_img_out=0, state IDLE, scan_cnt_out=0, cpu_rst_out=1 asynchronously.
